// File: rtl/branch_resolution_unit.sv
// Execute-side branch resolution: queues fetch predictions, checks them against
// resolved outcomes, and drives predictor training plus mispredict redirect.
module branch_resolution_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               push_valid_in,
    input  logic [31:0]        push_pc_in,
    input  logic               push_taken_pred_in,
    input  logic [31:0]        push_pred_pc_in,
    input  logic               resolve_valid_in,
    input  logic               actual_taken_in,
    input  logic [31:0]        actual_target_in,
    input  logic               flush_in,
    output logic               queue_full_out,
    output logic               queue_empty_out,
    output logic               feedback_enable_out,
    output logic               taken_branch_out,
    output logic [INDEX_W-1:0] pc_indx_branch_out,
    output logic               mispredict_out,
    output logic [31:0]        redirect_pc_out,
    output logic [CNT_W-1:0]   branch_count_out,
    output logic [CNT_W-1:0]   mispredict_count_out,
    output logic               error_out
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken_pred;
        logic [31:0] pred_pc;
    } pred_entry_t;

    pred_entry_t   queue_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_c;
    pred_entry_t   head_c;
    logic          pop_c;
    logic          push_c;
    logic          mispredict_c;
    logic          clear_c;
    logic          error_c;
    logic [31:0]   redirect_c;

    // Occupancy from the extra wrap bit of each pointer
    assign count_c         = wr_ptr - rd_ptr;
    assign queue_full_out  = (count_c == PW'(DEPTH));
    assign queue_empty_out = (count_c == '0);
    assign head_c          = queue_mem[rd_ptr[AW-1:0]];

    always_comb begin
        pop_c        = resolve_valid_in && !queue_empty_out;
        push_c       = push_valid_in && (!queue_full_out || pop_c);
        mispredict_c = pop_c && ((actual_taken_in != head_c.taken_pred) ||
                                 (actual_taken_in && (actual_target_in != head_c.pred_pc)));
        clear_c      = flush_in || mispredict_c;
        error_c      = (push_valid_in && queue_full_out && !pop_c) ||
                       (resolve_valid_in && queue_empty_out);
        redirect_c   = actual_taken_in ? actual_target_in : (head_c.pc + 32'd4);
    end

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clock_in) begin
        if (push_c) begin
            queue_mem[wr_ptr[AW-1:0]] <= '{pc: push_pc_in, taken_pred: push_taken_pred_in,
                                           pred_pc: push_pred_pc_in};
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_c);
            rd_ptr <= rd_ptr + PW'(pop_c);
        end
    end

    // Training, redirect and statistics, all one cycle after the resolve
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            feedback_enable_out  <= 1'b0;
            taken_branch_out     <= 1'b0;
            pc_indx_branch_out   <= '0;
            mispredict_out       <= 1'b0;
            redirect_pc_out      <= '0;
            branch_count_out     <= '0;
            mispredict_count_out <= '0;
            error_out            <= 1'b0;
        end else begin
            feedback_enable_out <= pop_c;
            mispredict_out      <= mispredict_c && !flush_in;
            if (error_c) begin
                error_out <= 1'b1;
            end
            if (pop_c) begin
                taken_branch_out   <= actual_taken_in;
                pc_indx_branch_out <= head_c.pc[INDEX_W-1:0];
                redirect_pc_out    <= redirect_c;
                if (branch_count_out != '1) begin
                    branch_count_out <= branch_count_out + CNT_W'(1);
                end
            end
            if (mispredict_c && (mispredict_count_out != '1)) begin
                mispredict_count_out <= mispredict_count_out + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed plus randomized bench for branch_resolution_unit against a queue-based
// reference model of the prediction/resolution rules.
module tb_branch_resolution_unit;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned INDEX_W = 10;
    localparam int unsigned CNT_W   = 16;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic               clock_in = 1'b0;
    logic               reset_in;
    logic               push_valid_in;
    logic [31:0]        push_pc_in;
    logic               push_taken_pred_in;
    logic [31:0]        push_pred_pc_in;
    logic               resolve_valid_in;
    logic               actual_taken_in;
    logic [31:0]        actual_target_in;
    logic               flush_in;
    logic               queue_full_out;
    logic               queue_empty_out;
    logic               feedback_enable_out;
    logic               taken_branch_out;
    logic [INDEX_W-1:0] pc_indx_branch_out;
    logic               mispredict_out;
    logic [31:0]        redirect_pc_out;
    logic [CNT_W-1:0]   branch_count_out;
    logic [CNT_W-1:0]   mispredict_count_out;
    logic               error_out;

    branch_resolution_unit #(.DEPTH(DEPTH), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clock_in             (clock_in),
        .reset_in             (reset_in),
        .push_valid_in        (push_valid_in),
        .push_pc_in           (push_pc_in),
        .push_taken_pred_in   (push_taken_pred_in),
        .push_pred_pc_in      (push_pred_pc_in),
        .resolve_valid_in     (resolve_valid_in),
        .actual_taken_in      (actual_taken_in),
        .actual_target_in     (actual_target_in),
        .flush_in             (flush_in),
        .queue_full_out       (queue_full_out),
        .queue_empty_out      (queue_empty_out),
        .feedback_enable_out  (feedback_enable_out),
        .taken_branch_out     (taken_branch_out),
        .pc_indx_branch_out   (pc_indx_branch_out),
        .mispredict_out       (mispredict_out),
        .redirect_pc_out      (redirect_pc_out),
        .branch_count_out     (branch_count_out),
        .mispredict_count_out (mispredict_count_out),
        .error_out            (error_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0] pc;
        logic        tp;
        logic [31:0] ppc;
    } ent_t;

    ent_t               mq[$];
    int                 m_bc;
    int                 m_mc;
    logic               m_err;
    logic               m_fb;
    logic               m_taken;
    logic               m_mis;
    logic [INDEX_W-1:0] m_idx;
    logic [31:0]        m_redir;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_bc = 0; m_mc = 0; m_err = 1'b0; m_fb = 1'b0; m_taken = 1'b0;
        m_mis = 1'b0; m_idx = '0; m_redir = '0;
    endtask

    task automatic check_all();
        chk("feedback_enable", 32'(feedback_enable_out), 32'(m_fb));
        chk("taken_branch", 32'(taken_branch_out), 32'(m_taken));
        chk("pc_index", 32'(pc_indx_branch_out), 32'(m_idx));
        chk("mispredict", 32'(mispredict_out), 32'(m_mis));
        chk("redirect_pc", redirect_pc_out, m_redir);
        chk("branch_count", 32'(branch_count_out), 32'(m_bc));
        chk("mispredict_count", 32'(mispredict_count_out), 32'(m_mc));
        chk("error", 32'(error_out), 32'(m_err));
        chk("queue_full", 32'(queue_full_out), 32'(mq.size() == DEPTH));
        chk("queue_empty", 32'(queue_empty_out), 32'(mq.size() == 0));
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic tp,
                         input logic [31:0] ppc, input logic rv, input logic at,
                         input logic [31:0] tgt, input logic fl);
        logic pop, acc, mis;
        ent_t h;
        push_valid_in = pv; push_pc_in = pc; push_taken_pred_in = tp; push_pred_pc_in = ppc;
        resolve_valid_in = rv; actual_taken_in = at; actual_target_in = tgt; flush_in = fl;
        pop = rv && (mq.size() > 0);
        acc = pv && ((mq.size() < DEPTH) || pop);
        if ((pv && mq.size() == DEPTH && !pop) || (rv && mq.size() == 0)) m_err = 1'b1;
        m_fb = pop; m_mis = 1'b0; mis = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            m_taken = at;
            m_idx = h.pc[INDEX_W-1:0];
            m_redir = at ? tgt : h.pc + 32'd4;
            mis = (at != h.tp) || (at && tgt != h.ppc);
            m_mis = mis && !fl;
            if (m_bc < CMAX) m_bc++;
            if (mis && m_mc < CMAX) m_mc++;
        end
        if (acc) mq.push_back('{pc, tp, ppc});
        if (fl || mis) mq.delete();
        @(posedge clock_in);
        #1;
        check_all();
    endtask

    task automatic push_only(input logic [31:0] pc, input logic tp, input logic [31:0] ppc);
        cycle(1'b1, pc, tp, ppc, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic resolve_only(input logic at, input logic [31:0] tgt);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, at, tgt, 1'b0);
    endtask

    task automatic random_cycle();
        logic pv, tp, rv, at, fl;
        logic [31:0] pc, ppc, tgt;
        pv  = 1'($urandom_range(0, 1));
        pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        tp  = 1'($urandom_range(0, 1));
        ppc = $urandom & 32'hFFFF_FFFC;
        rv  = ($urandom_range(0, 2) != 0);
        fl  = ($urandom_range(0, 31) == 0);
        at  = 1'($urandom_range(0, 1));
        tgt = $urandom & 32'hFFFF_FFFC;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            at  = mq[0].tp;
            tgt = mq[0].ppc;
        end
        cycle(pv, pc, tp, ppc, rv, at, tgt, fl);
    endtask

    initial begin
        reset_in = 1'b1;
        push_valid_in = 1'b0; push_pc_in = '0; push_taken_pred_in = 1'b0; push_pred_pc_in = '0;
        resolve_valid_in = 1'b0; actual_taken_in = 1'b0; actual_target_in = '0; flush_in = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clock_in);
        #1;
        check_all();
        reset_in = 1'b0;

        // Correct taken prediction
        push_only(32'h100, 1'b1, 32'h140);
        resolve_only(1'b1, 32'h140);
        chk("tp1_fb", 32'(feedback_enable_out), 32'd1);
        chk("tp1_idx", 32'(pc_indx_branch_out), 32'h100);

        // Predicted not-taken, resolved taken
        push_only(32'h200, 1'b0, 32'h0);
        resolve_only(1'b1, 32'h260);
        chk("tp2_redirect", redirect_pc_out, 32'h260);
        chk("tp2_mis", 32'(mispredict_out), 32'd1);

        // Predicted taken, resolved not-taken, same-cycle push discarded
        push_only(32'h300, 1'b1, 32'h380);
        cycle(1'b1, 32'h400, 1'b1, 32'h480, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("tp3_redirect", redirect_pc_out, 32'h304);
        chk("tp3_empty", 32'(queue_empty_out), 32'd1);

        // Fill, overflow, push+pop while full, drain in order
        for (int i = 0; i < 4; i++) push_only(32'h500 + 32'(i * 16), 1'b1, 32'h900 + 32'(i));
        chk("tp4_full", 32'(queue_full_out), 32'd1);
        push_only(32'h5F0, 1'b1, 32'h9F0);
        chk("tp4_err", 32'(error_out), 32'd1);
        cycle(1'b1, 32'h540, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 1'b0);
        chk("tp4_full_hold", 32'(queue_full_out), 32'd1);
        for (int i = 1; i < 4; i++) resolve_only(1'b1, 32'h900 + 32'(i));
        resolve_only(1'b0, 32'h0);

        // Resolve on empty, then flush with a same-cycle correct resolve
        resolve_only(1'b1, 32'h123);
        chk("tp5_nofb", 32'(feedback_enable_out), 32'd0);
        for (int i = 0; i < 3; i++) push_only(32'h700 + 32'(i * 4), 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("tp5_flush_mis", 32'(mispredict_out), 32'd0);

        // Fall-through redirect wraps at 2^32
        push_only(32'hFFFF_FFFC, 1'b1, 32'h40);
        resolve_only(1'b0, 32'h0);
        chk("wrap_redirect", redirect_pc_out, 32'h0);

        for (int i = 0; i < 1500; i++) random_cycle();

        // Saturate the branch counter with back-to-back correct resolves
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        push_only(32'h1000, 1'b1, 32'h2000);
        for (int i = 0; i < 65600; i++)
            cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000, 1'b1, 1'b1, 32'h2000, 1'b0);
        chk("bc_saturated", 32'(branch_count_out), 32'hFFFF);

        // Asynchronous reset between edges
        #2;
        reset_in = 1'b1;
        #1;
        model_reset();
        chk("arst_bc", 32'(branch_count_out), 32'd0);
        chk("arst_fb", 32'(feedback_enable_out), 32'd0);
        check_all();
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        for (int i = 0; i < 40; i++) random_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Execute-side end of the branch prediction loop. It queues every prediction issued at fetch, matches each against the branch outcome resolved in execute, and produces the predictor training feedback (enable, taken, 10-bit table index). On a misprediction it also produces a redirect PC and flush. Sits between the fetch-stage predictor and the execute-stage branch comparator; outputs drive the predictor feedback port and the PC-select logic.

## Interface
- DEPTH, 4: prediction queue entries (power of two, ≥2)
- INDEX_W, 10: width of predictor table index (PC bits [INDEX_W-1:0])
- CNT_W, 16: statistics counter width

- clock_in  input  1  system clock, all state on rising edge
- reset_in  input  1  asynchronous, active-high reset
- push_valid_in  input  1  fetch issued a prediction for a branch this cycle
- push_pc_in  input  32  PC of predicted branch
- push_taken_pred_in  input  1  predicted direction
- push_pred_pc_in  input  32  predicted target (don't-care if not taken)
- resolve_valid_in  input  1  execute resolved oldest in-flight branch this cycle
- actual_taken_in  input  1  resolved direction
- actual_target_in  input  32  resolved taken target
- flush_in  input  1  external pipeline flush (trap/interrupt)
- queue_full_out  output  1  queue holds DEPTH entries
- queue_empty_out  output  1  queue holds 0 entries
- feedback_enable_out  output  1  one-cycle training pulse to predictor
- taken_branch_out  output  1  resolved direction for training
- pc_indx_branch_out  output  INDEX_W  table index for training
- mispredict_out  output  1  one-cycle redirect pulse
- redirect_pc_out  output  32  correct next PC, valid with mispredict_out
- branch_count_out  output  CNT_W  resolved branches, saturating
- mispredict_count_out  output  CNT_W  mispredictions, saturating
- error_out  output  1  sticky protocol error

## Operation
- Queue: circular FIFO of {pc, taken_pred, pred_pc}; write/read pointers with one extra wrap bit; count = wr − rd. full when count==DEPTH, empty when count==0 (both combinational from pointers).
- Push: when push_valid_in and (not full or pop this cycle), write at tail, advance wr. Push while full without pop: dropped, error_out set.
- Resolve: when resolve_valid_in and not empty, compare against head, pop head. Resolve while empty: ignored, error_out set, no feedback.
- Mispredict if actual_taken_in != head.taken_pred, or both taken and actual_target_in != head.pred_pc.
- Redirect PC: actual_taken_in ? actual_target_in : head.pc + 4 (32-bit wrap modulo 2^32).
- On mispredict: all entries (including a same-cycle push) discarded; wr = rd = 0.
- flush_in: discards all entries and same-cycle push; a same-cycle valid resolve still generates feedback and counters (branch was resolved) but mispredict_out is suppressed (external flush owns redirect).
- Feedback every valid resolve: taken_branch_out = actual_taken_in, pc_indx_branch_out = head.pc[INDEX_W-1:0].
- Counters: branch_count +1 per valid resolve; mispredict_count +1 per detected mispredict (even if suppressed by flush_in); both hold at all-ones.
- error_out sticky until reset.

## Timing
- Reset (async, immediate): pointers 0, queue_empty_out=1, queue_full_out=0, feedback_enable_out=0, taken_branch_out=0, pc_indx_branch_out=0, mispredict_out=0, redirect_pc_out=0, counters 0, error_out=0.
- Feedback, mispredict and redirect outputs registered: asserted exactly 1 cycle after the resolve_valid_in cycle, for 1 cycle; taken/index/redirect hold last value otherwise.
- Pushed entry is resolvable the cycle after push (no same-cycle push→resolve bypass into an empty queue).
- Simultaneous push+resolve with full queue: both take effect, count unchanged (unless mispredict/flush clears).
- Counters update on same edge as feedback.
- Back-to-back resolves every cycle supported; throughput 1/cycle.

## Test plan
- Reset then push pc=0x100, taken_pred=1, pred_pc=0x140; resolve taken, target 0x140 → next cycle feedback_enable_out=1, taken_branch_out=1, pc_indx_branch_out=0x100, mispredict_out=0; branch_count=1.
- Push pc=0x200 pred not-taken; resolve taken target 0x260 → mispredict_out=1, redirect_pc_out=0x260, mispredict_count=1, queue_empty_out=1.
- Push pc=0x300 pred taken 0x380; resolve not-taken → redirect_pc_out=0x304; push in same resolve cycle discarded (queue empty after).
- Push 4 entries → queue_full_out=1; 5th push alone → dropped, error_out=1; push+resolve same cycle while full → accepted, full stays 1; drain 4 in order, pc indices in FIFO order.
- Resolve on empty queue → no feedback pulse, error_out=1; flush_in with 3 entries + same-cycle correct resolve → feedback pulse, mispredict_out=0, queue empty.
- Force branch_count to 0xFFFF via 65535 resolves, one more → stays 0xFFFF; assert reset_in mid-run asynchronously → all outputs zero before next edge.
